// File: rtl/synapse_pkg.sv
// rtl/synapse_pkg.sv - shared types and default sizes for the synapse weight table
package synapse_pkg;

    localparam int WEIGHT_W_DEF = 8;
    localparam int ADDR_W_DEF   = 8;

    typedef logic [WEIGHT_W_DEF-1:0] weight_t;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_DUMP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/synapse_bram_dp.sv
// rtl/synapse_bram_dp.sv - simple dual-port RAM, one write port, one synchronous read-first read port
//
// Ports:
//   clk          clock
//   we/waddr/wdata  write port, committed on the rising edge
//   re/raddr     read strobe and address
//   rdata        read data, updated one edge after re; holds when re is low
// The array has no reset; its contents are established by the owner.
module synapse_bram_dp #(
    parameter int W  = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    localparam int DEPTH = 2**AW;

    logic [W-1:0] mem [DEPTH];

    // Read and write in one block: the read samples the array before the
    // write lands, so a same-address collision returns the old value.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/synapse_weight_table.sv
// rtl/synapse_weight_table.sv - synapse weight store with self-clear after reset and kill-triggered dump
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   w_en/w_addr/w_data       user write port (IDLE only)
//   r_en/r_addr              user read request (IDLE only)
//   r_data/r_valid           read result, one cycle after the request
//   kill                     starts a dump of the whole table (IDLE only)
//   dump_addr/dump_data      current dump beat
//   dump_valid/dump_ready    dump handshake
//   dump_done                one-cycle pulse after the last beat
//   busy                     high while clearing or dumping
module synapse_weight_table
    import synapse_pkg::*;
#(
    parameter int                     WEIGHT_W      = WEIGHT_W_DEF,
    parameter int                     ADDR_W        = ADDR_W_DEF,
    parameter logic [WEIGHT_W-1:0]    INIT_VAL      = '0,
    parameter int                     CLEAR_ON_DUMP = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [WEIGHT_W-1:0] w_data,
    input  logic                r_en,
    input  logic [ADDR_W-1:0]   r_addr,
    output logic [WEIGHT_W-1:0] r_data,
    output logic                r_valid,
    input  logic                kill,
    output logic [ADDR_W-1:0]   dump_addr,
    output logic [WEIGHT_W-1:0] dump_data,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic                dump_done,
    output logic                busy
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   clr_addr;
    logic                hs;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [WEIGHT_W-1:0] ram_wdata;
    logic                ram_re;
    logic [ADDR_W-1:0]   ram_raddr;
    logic [WEIGHT_W-1:0] ram_q;

    assign hs        = dump_valid && dump_ready;
    assign busy      = (state != ST_IDLE);
    assign dump_done = (state == ST_DONE);

    // The RAM read register is shared by both consumers and has no reset;
    // qualifying it with each valid keeps both data outputs at 0 in reset.
    // While a dump beat stalls no new read is issued, so dump_data holds.
    assign r_data    = r_valid    ? ram_q : '0;
    assign dump_data = dump_valid ? ram_q : '0;

    synapse_bram_dp #(
        .W  (WEIGHT_W),
        .AW (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // Next state and RAM port ownership.
    always_comb begin
        state_nx  = state;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_raddr = '0;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = INIT_VAL;
                if (clr_addr == LAST) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ram_we    = w_en;
                ram_waddr = w_addr;
                ram_wdata = w_data;
                ram_re    = r_en;
                ram_raddr = r_addr;
                if (kill) begin
                    state_nx = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (!dump_valid) begin
                    // First cycle of the dump: fetch entry 0.
                    ram_re    = 1'b1;
                    ram_raddr = '0;
                end else if (hs) begin
                    if (CLEAR_ON_DUMP != 0) begin
                        ram_we    = 1'b1;
                        ram_waddr = dump_addr;
                        ram_wdata = INIT_VAL;
                    end
                    if (dump_addr == LAST) begin
                        state_nx = ST_DONE;
                    end else begin
                        // Prefetch the next entry on the handshake so the
                        // stream runs at one beat per cycle.
                        ram_re    = 1'b1;
                        ram_raddr = dump_addr + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_CLEAR;
            clr_addr   <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            r_valid    <= 1'b0;
        end else begin
            state   <= state_nx;
            r_valid <= (state == ST_IDLE) && r_en;
            if (state == ST_CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end
            if (state == ST_DUMP) begin
                if (!dump_valid) begin
                    dump_valid <= 1'b1;
                    dump_addr  <= '0;
                end else if (hs) begin
                    if (dump_addr == LAST) begin
                        dump_valid <= 1'b0;
                    end else begin
                        dump_addr <= dump_addr + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/synapse_weight_table.md
# synapse_weight_table

Parametrised synapse weight store for the spiking-neuron datapath: one weight per presynaptic neuron number, with a single-cycle write port and a registered read port. Adds what the 8x256 weight BRAM lacked: self-initialisation after reset, a kill-triggered dump that streams the whole table out under valid/ready, and an optional clear-on-dump mode. It sits between the neuron core, which addresses weights by neuron number, and the readout/host path, which consumes dumps.

## Interface
- `WEIGHT_W`, 8: weight width in bits.
- `ADDR_W`, 8: neuron-number width; depth is `DEPTH = 2**ADDR_W`.
- `INIT_VAL`, 0: value written to every entry by the clear sweep.
- `CLEAR_ON_DUMP`, 0: when 1, each entry is overwritten with `INIT_VAL` as it is dumped.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `w_en` in 1: write strobe.
- `w_addr` in ADDR_W: write neuron number.
- `w_data` in WEIGHT_W: write weight.
- `r_en` in 1: read strobe.
- `r_addr` in ADDR_W: read neuron number.
- `r_data` out WEIGHT_W: read weight, registered.
- `r_valid` out 1: `r_data` valid for one cycle.
- `kill` in 1: dump request.
- `dump_addr` out ADDR_W: neuron number of the current dump beat.
- `dump_data` out WEIGHT_W: weight of the current dump beat.
- `dump_valid` out 1: dump beat valid.
- `dump_ready` in 1: consumer accepts the beat.
- `dump_done` out 1: one-cycle pulse after the last beat.
- `busy` out 1: block is in CLEAR or DUMP; port accesses are ignored.

## Operation
- FSM states: CLEAR, IDLE, DUMP, DONE.
- Reset values: state CLEAR, sweep counter 0, `busy` 1, all other outputs 0.
- **CLEAR:** writes `INIT_VAL` to address 0..DEPTH-1, one entry per cycle. After address DEPTH-1 is written, goes to IDLE and `busy` falls.
- **IDLE, write:** `w_en` writes `w_data` to `w_addr`.
- **IDLE, read:** `r_en` registers the weight at `r_addr` into `r_data` and pulses `r_valid`.
- **Read and write in the same cycle:** independent ports.
- **Read and write to the same address:** read-first; the read returns the old value.
- **IDLE with `kill`=1:** goes to DUMP. `w_en`/`r_en` in that same cycle are still honoured.
- **DUMP:** streams entries 0..DEPTH-1 in ascending order on `dump_addr`/`dump_data`.
  - A beat transfers when `dump_valid && dump_ready`.
  - While `dump_ready`=0, `dump_valid`, `dump_addr` and `dump_data` hold stable.
  - `dump_valid` never drops before its handshake.
  - If `CLEAR_ON_DUMP`=1, the entry is overwritten with `INIT_VAL` in the handshake cycle.
- **DONE:** entered on the handshake of entry DEPTH-1. `dump_done`=1 for exactly one cycle, then IDLE.
- **While `busy`:** `w_en`, `r_en` and `kill` are ignored, with no queuing; `r_valid` stays 0.
- **`rst` asserted mid-CLEAR or mid-DUMP:** aborts immediately; outputs return to reset values and CLEAR restarts.
- **Address counters:** ADDR_W bits wide. DEPTH-1 is the terminal value; no wrap-around is observed.

## Timing
- Read latency is 1: `r_en` sampled at edge N gives `r_data`/`r_valid` after edge N.
- Write is visible to a read issued on the next cycle.
- CLEAR lasts exactly DEPTH cycles after `rst` deasserts; `busy`=0 from cycle DEPTH.
- Dump start: `kill` sampled at edge N; `busy`=1 after edge N; the first beat (addr 0) is valid after edge N+1, i.e. memory latency of 1.
- Dump throughput: with `dump_ready` held 1, one beat per cycle. A full dump is DEPTH beats, then `dump_done` on the cycle after the last handshake. Dump start to `busy`=0 takes DEPTH+2 cycles.
- Back-pressure adds exactly one cycle per cycle `dump_ready`=0 while valid. This requires prefetching the next address on a handshake, not a bubble.

## Structure
- Shared package `synapse_pkg` holds:
  - the FSM state enum (CLEAR, IDLE, DUMP, DONE);
  - the default `WEIGHT_W`/`ADDR_W` constants;
  - the weight typedef.
- One sub-module, `synapse_bram_dp`: a simple dual-port RAM with one write port, one synchronous read port, read-first behaviour and no reset on the array.
- The top level muxes the RAM ports between the user, the CLEAR sweep and the DUMP engine.

## Test plan
- **Reset clear:** release `rst` with defaults. `busy`=1 for 256 cycles, then 0. Reads of addresses 0, 17 and 255 all return 0.
- **Write/read:** write 0xA5@0x03, read 0x03 the next cycle; `r_data`=0xA5 with `r_valid` one cycle later.
- **Same-cycle read/write:** write 0x3C@0x10 together with a read of 0x10 returns the old value; the following read returns 0x3C.
- **Full dump, `dump_ready`=1:** after preloading addr k with k^0xFF, pulse `kill`. Expect 256 consecutive beats with `dump_data`=k^0xFF, `dump_done` on the cycle after beat 255, and total `busy` of 258 cycles.
- **Back-pressure with `CLEAR_ON_DUMP`=1:** drive `dump_ready` with a random 50% duty cycle. Beats are in order with no drops or duplicates and data held while stalled. A post-dump read of every address returns `INIT_VAL`.
- **Reset mid-dump and access while busy:** assert `rst` at beat 100. All outputs go to reset values and a fresh 256-cycle CLEAR follows. Separately, `w_en` during DUMP leaves the table unchanged.
